// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: timer register map, CTRL bit
// positions, legal byte-enable codes and store-lane alignment.
package dmem_ctrl_pkg;

    // Timer registers sit at byte offsets 0/4/8; the enum value is offset[3:2].
    typedef enum logic [1:0] {
        TREG_MTIME    = 2'd0,
        TREG_MTIMECMP = 2'd1,
        TREG_CTRL     = 2'd2
    } treg_e;

    localparam int unsigned TIMER_WINDOW_BYTES = 12;
    localparam int unsigned CTRL_IE_BIT        = 0;
    localparam int unsigned CTRL_PEND_BIT      = 1;

    localparam logic [3:0] BE_B0 = 4'b0001;
    localparam logic [3:0] BE_B1 = 4'b0010;
    localparam logic [3:0] BE_B2 = 4'b0100;
    localparam logic [3:0] BE_B3 = 4'b1000;
    localparam logic [3:0] BE_H0 = 4'b0011;
    localparam logic [3:0] BE_H1 = 4'b1100;
    localparam logic [3:0] BE_W  = 4'b1111;

    function automatic logic be_legal(input logic [3:0] be);
        case (be)
            BE_B0, BE_B1, BE_B2, BE_B3, BE_H0, BE_H1, BE_W: be_legal = 1'b1;
            default:                                        be_legal = 1'b0;
        endcase
    endfunction

    // Replicate the low byte/half across the word so the enabled lanes pick it up.
    function automatic logic [31:0] lane_align(input logic [3:0] be, input logic [31:0] wd);
        case (be)
            BE_B0, BE_B1, BE_B2, BE_B3: lane_align = {4{wd[7:0]}};
            BE_H0, BE_H1:               lane_align = {2{wd[15:0]}};
            default:                    lane_align = wd;
        endcase
    endfunction

endpackage

// File: rtl/dmem_timer.sv
// Free-running MTIME/MTIMECMP timer with compare-pending flag and registered interrupt.
// Only instantiated when DMEM_TIMER_EN is defined.
module dmem_timer
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr,
    input  treg_e                sel,
    input  logic [DATAWIDTH-1:0] wdata,
    output logic [DATAWIDTH-1:0] rdata,
    output logic                 irq
);

    logic [DATAWIDTH-1:0] mtime;
    logic [DATAWIDTH-1:0] mtimecmp;
    logic                 ie;
    logic                 pend;

    always_ff @(posedge clk) begin
        if (reset) begin
            mtime    <= '0;
            mtimecmp <= '0;
            ie       <= 1'b0;
            pend     <= 1'b0;
            irq      <= 1'b0;
        end else begin
            mtime <= (wr && sel == TREG_MTIME) ? wdata : mtime + DATAWIDTH'(1);
            if (wr && sel == TREG_MTIMECMP)
                mtimecmp <= wdata;
            if (wr && sel == TREG_CTRL)
                ie <= wdata[CTRL_IE_BIT];
            // A compare match outranks a write-1-to-clear in the same cycle.
            if (mtime == mtimecmp)
                pend <= 1'b1;
            else if (wr && sel == TREG_CTRL && wdata[CTRL_PEND_BIT])
                pend <= 1'b0;
            irq <= pend & ie;
        end
    end

    always_comb begin
        rdata = '0;
        case (sel)
            TREG_MTIME:    rdata = mtime;
            TREG_MTIMECMP: rdata = mtimecmp;
            TREG_CTRL: begin
                rdata[CTRL_IE_BIT]   = ie;
                rdata[CTRL_PEND_BIT] = pend;
            end
            default:       rdata = '0;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: on-chip word RAM with byte-lane stores, 1-cycle reads and a
// sticky illegal-access flag. Define DMEM_TIMER_EN to map the timer at TIMER_BASE.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned DATAWIDTH   = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] TIMER_BASE  = 32'hFFFF_0000
) (
    input  logic                 DMEM_Clk_in,
    input  logic                 DMEM_Reset_in,
    input  logic                 DMEM_Read_in,
    input  logic                 DMEM_Write_in,
    input  logic [3:0]           DMEM_Byteenable_InBUS,
    input  logic [DATAWIDTH-1:0] DMEM_Addr_InBUS,
    input  logic [DATAWIDTH-1:0] DMEM_Writedata_InBUS,
    output logic [DATAWIDTH-1:0] DMEM_Readdata_OutBUS,
    output logic                 DMEM_Readvalid_Out,
    output logic                 DMEM_Error_Out,
    output logic                 DMEM_Timer_Irq_Out
);

    localparam int unsigned          AW        = $clog2(DEPTH_WORDS);
    localparam logic [DATAWIDTH-1:0] RAM_BYTES = DATAWIDTH'(DEPTH_WORDS * 4);

    logic [DATAWIDTH-1:0] mem [DEPTH_WORDS];
    logic [AW-1:0]        word_idx;
    logic                 in_ram;
    logic                 in_timer;
    logic                 be_ok;
    logic                 ram_we;
    logic                 wr_err;
    logic                 rd_err;
    logic [DATAWIDTH-1:0] wr_lanes;
    logic [DATAWIDTH-1:0] tmr_rdata;

    assign word_idx = DMEM_Addr_InBUS[AW+1:2];
    assign in_ram   = DMEM_Addr_InBUS < RAM_BYTES;
    assign be_ok    = be_legal(DMEM_Byteenable_InBUS);
    assign wr_lanes = lane_align(DMEM_Byteenable_InBUS, DMEM_Writedata_InBUS);

`ifdef DMEM_TIMER_EN
    logic [DATAWIDTH-1:0] tmr_off;
    logic                 tmr_wr;

    assign tmr_off  = DMEM_Addr_InBUS - TIMER_BASE;
    assign in_timer = tmr_off < DATAWIDTH'(TIMER_WINDOW_BYTES);
    assign tmr_wr   = DMEM_Write_in && !DMEM_Reset_in && in_timer
                      && DMEM_Byteenable_InBUS == BE_W;

    dmem_timer #(
        .DATAWIDTH(DATAWIDTH)
    ) u_timer (
        .clk   (DMEM_Clk_in),
        .reset (DMEM_Reset_in),
        .wr    (tmr_wr),
        .sel   (treg_e'(tmr_off[3:2])),
        .wdata (DMEM_Writedata_InBUS),
        .rdata (tmr_rdata),
        .irq   (DMEM_Timer_Irq_Out)
    );
`else
    assign in_timer           = 1'b0;
    assign tmr_rdata          = '0;
    assign DMEM_Timer_Irq_Out = 1'b0;
`endif

    assign ram_we = DMEM_Write_in && !DMEM_Reset_in && in_ram && be_ok;
    assign wr_err = DMEM_Write_in && !(in_ram ? be_ok
                                              : (in_timer && DMEM_Byteenable_InBUS == BE_W));
    assign rd_err = DMEM_Read_in && !in_ram && !in_timer;

    always_ff @(posedge DMEM_Clk_in) begin
        if (ram_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (DMEM_Byteenable_InBUS[i])
                    mem[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
            end
        end
    end

    // The read samples mem before this edge's store lands, giving read-before-write.
    always_ff @(posedge DMEM_Clk_in) begin
        if (DMEM_Reset_in) begin
            DMEM_Readdata_OutBUS <= '0;
            DMEM_Readvalid_Out   <= 1'b0;
            DMEM_Error_Out       <= 1'b0;
        end else begin
            DMEM_Readvalid_Out <= DMEM_Read_in;
            if (DMEM_Read_in)
                DMEM_Readdata_OutBUS <= in_ram   ? mem[word_idx] :
                                        in_timer ? tmr_rdata     : '0;
            if (wr_err || rd_err)
                DMEM_Error_Out <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: directed scenarios plus random traffic against a
// word-array reference model; timer checks are compiled in with DMEM_TIMER_EN.
module tb_dmem_ctrl;

    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] TBASE = 32'hFFFF_0000;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        rd   = 1'b0;
    logic        wr   = 1'b0;
    logic [3:0]  be   = 4'h0;
    logic [31:0] addr = '0;
    logic [31:0] wd   = '0;
    logic [31:0] rdata;
    logic        rvalid;
    logic        err;
    logic        irq;

    dmem_ctrl #(
        .DATAWIDTH   (32),
        .DEPTH_WORDS (DEPTH),
        .TIMER_BASE  (TBASE)
    ) dut (
        .DMEM_Clk_in           (clk),
        .DMEM_Reset_in         (rst),
        .DMEM_Read_in          (rd),
        .DMEM_Write_in         (wr),
        .DMEM_Byteenable_InBUS (be),
        .DMEM_Addr_InBUS       (addr),
        .DMEM_Writedata_InBUS  (wd),
        .DMEM_Readdata_OutBUS  (rdata),
        .DMEM_Readvalid_Out    (rvalid),
        .DMEM_Error_Out        (err),
        .DMEM_Timer_Irq_Out    (irq)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    logic [31:0] mdl [DEPTH];
    logic        mdl_err  = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] mt_v     = '0;
    int unsigned mt_edge  = 0;
    logic [31:0] mt_cmp   = '0;
    logic [31:0] exp_ctrl = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic bit legal(input logic [3:0] b);
        return b == 4'b0001 || b == 4'b0010 || b == 4'b0100 || b == 4'b1000 ||
               b == 4'b0011 || b == 4'b1100 || b == 4'b1111;
    endfunction

    // Enabled lanes take consecutive bytes of the store data, starting at byte 0.
    function automatic logic [31:0] apply_store(input logic [31:0] old, input logic [3:0] b,
                                                input logic [31:0] d);
        logic [31:0] r;
        int          first;
        r     = old;
        first = 0;
        for (int k = 3; k >= 0; k--) if (b[k]) first = k;
        for (int k = 0; k < 4; k++) if (b[k]) r[8*k +: 8] = d[8*(k-first) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] tmr_read(input logic [1:0] sel, input int unsigned n);
        case (sel)
            2'd0:    return mt_v + (n - mt_edge - 1);
            2'd1:    return mt_cmp;
            default: return exp_ctrl;
        endcase
    endfunction

    // Drive one cycle's inputs (caller is at a negedge) and advance the model to that edge.
    task automatic do_op(input logic r_, input logic w_, input logic [3:0] b_,
                         input logic [31:0] a_, input logic [31:0] d_, input logic rs_);
        int unsigned n;
        int unsigned idx;
        logic        inr;
        logic        intm;
        logic [31:0] off;
        rst = rs_; rd = r_; wr = w_; be = b_; addr = a_; wd = d_;
        n    = cyc + 1;
        idx  = a_ >> 2;
        inr  = a_ < DEPTH * 4;
        off  = a_ - TBASE;
`ifdef DMEM_TIMER_EN
        intm = off < 12;
`else
        intm = 1'b0;
`endif
        if (rs_) begin
            mdl_err = 1'b0; mt_v = '0; mt_edge = n; mt_cmp = '0; exp_ctrl = '0;
            return;
        end
        if (r_) begin
            if (inr)       exp_q.push_back(mdl[idx]);
            else if (intm) exp_q.push_back(tmr_read(off[3:2], n));
            else begin
                exp_q.push_back(32'h0);
                mdl_err = 1'b1;
            end
        end
        if (w_) begin
            if (inr) begin
                if (legal(b_)) mdl[idx] = apply_store(mdl[idx], b_, d_);
                else           mdl_err = 1'b1;
            end else if (intm && b_ == 4'hF) begin
                case (off[3:2])
                    2'd0: begin mt_v = d_; mt_edge = n; end
                    2'd1: mt_cmp = d_;
                    default: begin
                        exp_ctrl[0] = d_[0];
                        if (d_[1]) exp_ctrl[1] = 1'b0;
                    end
                endcase
            end else begin
                mdl_err = 1'b1;
            end
        end
    endtask

    task automatic wr_op(input logic [3:0] b_, input logic [31:0] a_, input logic [31:0] d_);
        @(negedge clk); do_op(1'b0, 1'b1, b_, a_, d_, 1'b0);
    endtask
    task automatic rd_op(input logic [31:0] a_);
        @(negedge clk); do_op(1'b1, 1'b0, 4'hF, a_, 32'h0, 1'b0);
    endtask
    task automatic idle();
        @(negedge clk); do_op(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    endtask
    task automatic rst_op(input logic w_, input logic [31:0] a_, input logic [31:0] d_);
        @(negedge clk); do_op(1'b0, w_, 4'hF, a_, d_, 1'b1);
    endtask

    task automatic rand_phase(input int n, input bit allow_bad);
        logic [3:0] be_tab [7];
        be_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        for (int i = 0; i < n; i++) begin
            logic [31:0] a;
            logic [3:0]  b;
            int unsigned kind;
            kind = $urandom % 10;
            if ($urandom % 2 == 0) a = (($urandom % 8) << 2) | ($urandom % 4);
            else                   a = (($urandom % DEPTH) << 2) | ($urandom % 4);
            b = be_tab[$urandom % 7];
            if (allow_bad && $urandom % 10 == 0)
                a = ($urandom % 2 == 0) ? DEPTH * 4 + ($urandom % 256) : 32'h4000_0000 + ($urandom % 4096);
            if (allow_bad && $urandom % 10 == 0)
                do b = 4'($urandom); while (legal(b));
            @(negedge clk);
            do_op(kind < 4 || kind >= 8, kind >= 4 && kind < 9, b, a, $urandom, 1'b0);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents read data.
    logic [31:0] hold_val = '0;
    always @(posedge clk) begin
        logic rs;
        rs = rst;
        #1;
        check("error", 32'(err), 32'(mdl_err));
        if (rs) begin
            check("reset_rvalid", 32'(rvalid), 32'h0);
            check("reset_rdata", rdata, 32'h0);
            check("reset_irq", 32'(irq), 32'h0);
            hold_val = '0;
        end else if (rvalid) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL spurious_rvalid: got rvalid=1 rdata=%h expected no read pending", rdata);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("rdata", rdata, e);
                hold_val = e;
            end
        end else begin
            check("hold", rdata, hold_val);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned w_edge;
        repeat (3) rst_op(1'b0, 32'h0, 32'h0);
        for (int i = 0; i < int'(DEPTH); i++) wr_op(4'hF, 32'(i * 4), $urandom);

        wr_op(4'hF, 32'h10, 32'hDEAD_BEEF); rd_op(32'h10);
        wr_op(4'hF, 32'h10, 32'h0);
        wr_op(4'b0100, 32'h10, 32'h0000_00A5); rd_op(32'h10);
        wr_op(4'b1100, 32'h10, 32'h0000_1234); rd_op(32'h10);
        wr_op(4'hF, 32'h20, 32'h1111_1111);
        @(negedge clk); do_op(1'b1, 1'b1, 4'hF, 32'h20, 32'h2222_2222, 1'b0);
        rd_op(32'h20);
        wr_op(4'hF, 32'h30, 32'hA0A0_A0A0);
        rst_op(1'b1, 32'h30, 32'h5555_5555);
        rd_op(32'h30);
        idle();

        rand_phase(250, 1'b0);

        rd_op(DEPTH * 4);
        wr_op(4'hF, 32'h40, 32'hCAFE_F00D); rd_op(32'h40);
        rand_phase(250, 1'b1);
        rst_op(1'b0, 32'h0, 32'h0);
        rd_op(32'h44);

`ifdef DMEM_TIMER_EN
        rst_op(1'b0, 32'h0, 32'h0);
        rd_op(TBASE);
        wr_op(4'hF, TBASE + 8, 32'h2);
        rd_op(TBASE + 8);
        @(negedge clk);
        w_edge = cyc + 1;
        do_op(1'b0, 1'b1, 4'hF, TBASE + 4, tmr_read(2'd0, w_edge) + 32'd5, 1'b0);
        wr_op(4'hF, TBASE + 8, 32'h1);
        for (int k = 0; k < 8; k++) begin
            idle();
            @(posedge clk); #1;
            check("irq_rise", 32'(irq), 32'(cyc >= w_edge + 6));
        end
        exp_ctrl = 32'h3;
        rd_op(TBASE + 8);
        wr_op(4'hF, TBASE + 8, 32'h3);
        idle(); idle();
        @(posedge clk); #1;
        check("irq_clear", 32'(irq), 32'h0);
        rd_op(TBASE + 8);
        rd_op(TBASE + 4);
        wr_op(4'hF, TBASE, 32'hFFFF_FFFF);
        idle();
        rd_op(TBASE);
        wr_op(4'b0011, TBASE + 4, 32'h0);
        rd_op(TBASE + 4);
`else
        w_edge = 0;
        rd_op(TBASE);
        wr_op(4'hF, TBASE + 4, 32'h1234_5678);
        check("irq_tied", 32'(irq) + w_edge, 32'h0);
`endif

        repeat (3) idle();
        @(posedge clk); #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d reads outstanding expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
